// File: rtl/mc_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, default width.
package mc_alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // ALUControl encodings (single-cycle encodings unchanged from the old ALU)
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULU = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mc_alu_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit
// per cycle. hi/lo carry the value after the current step, so on the done
// cycle they already hold the final product/quotient and remainder.
module mc_alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic             busy_reg;
  logic             div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] opnd_reg;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             last_step;

  assign last_step = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));

  // One iteration step: {hi,lo} is product accumulator / {remainder,quotient}
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    hi_next   = hi_reg;
    lo_next   = lo_reg;
    if (div_reg) begin
      // Top bit of the difference set means the trial subtraction borrowed
      if (!div_diff[WIDTH]) begin
        hi_next = div_diff[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_shift[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // Operand load on start, then WIDTH iteration steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      div_reg  <= 1'b0;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      opnd_reg <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      div_reg  <= is_div;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= is_div ? a : b;
      opnd_reg <= is_div ? b : a;
    end else if (busy_reg) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
      if (last_step) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign busy = busy_reg;
  assign done = last_step;
  assign lo   = lo_next;
  assign hi   = hi_next;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle datapath and flags, start/done handshake FSM,
// iterative MULU/DIVU via mc_alu_muldiv, and held output registers.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALUControl,
  input  logic [SHAMT_W-1:0] ShiftAmount,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   ALUOut,
  output logic [WIDTH-1:0]   ALUOutHi,
  output logic               Zero,
  output logic               Overflow,
  output logic               CarryOut,
  output logic               DivByZero
);

  state_t           state_reg, state_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;
  logic             carry_reg, carry_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_carry;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;

  logic             eng_start;
  logic             eng_busy;
  logic             eng_done;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;

  mc_alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .is_div (ALUControl == OP_DIVU),
    .a      (A),
    .b      (B),
    .busy   (eng_busy),
    .done   (eng_done),
    .lo     (eng_lo),
    .hi     (eng_hi)
  );

  // Single-cycle datapath and its ADD/SUB flags
  always_comb begin
    add_full = {1'b0, A} + {1'b0, B};
    sub_res  = A - B;
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_carry = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        sc_res   = add_full[WIDTH-1:0];
        sc_carry = add_full[WIDTH];
        sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_res;
        sc_carry = (A < B);
        sc_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  sc_res = A << ShiftAmount;
      OP_SRL:  sc_res = A >> ShiftAmount;
      OP_SRA:  sc_res = $unsigned($signed(A) >>> ShiftAmount);
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: sc_res = '0;
    endcase
  end

  // FSM next state and output-register next values; outputs hold by default
  always_comb begin
    state_next = state_reg;
    eng_start  = 1'b0;
    done_next  = 1'b0;
    out_next   = out_reg;
    hi_next    = hi_reg;
    ovf_next   = ovf_reg;
    carry_next = carry_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (start && ready) begin
          if (ALUControl == OP_MULU) begin
            eng_start  = 1'b1;
            state_next = MUL;
          end else if (ALUControl == OP_DIVU && B != '0) begin
            eng_start  = 1'b1;
            state_next = DIV;
          end else if (ALUControl == OP_DIVU) begin
            done_next  = 1'b1;
            out_next   = '1;
            hi_next    = A;
            ovf_next   = 1'b0;
            carry_next = 1'b0;
            dbz_next   = 1'b1;
          end else begin
            done_next  = 1'b1;
            out_next   = sc_res;
            hi_next    = '0;
            ovf_next   = sc_ovf;
            carry_next = sc_carry;
            dbz_next   = 1'b0;
          end
        end
      end
      MUL, DIV: begin
        if (eng_done) begin
          state_next = IDLE;
          done_next  = 1'b1;
          out_next   = eng_lo;
          hi_next    = eng_hi;
          ovf_next   = 1'b0;
          carry_next = 1'b0;
          dbz_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    zero_next = (out_next == '0) && (done_next || zero_reg && (out_next == out_reg));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
      out_reg   <= '0;
      hi_reg    <= '0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      carry_reg <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      out_reg   <= out_next;
      hi_reg    <= hi_next;
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
      carry_reg <= carry_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign ready     = (state_reg == IDLE) && !eng_busy;
  assign done      = done_reg;
  assign ALUOut    = out_reg;
  assign ALUOutHi  = hi_reg;
  assign Zero      = zero_reg;
  assign Overflow  = ovf_reg;
  assign CarryOut  = carry_reg;
  assign DivByZero = dbz_reg;

endmodule

// File: tb/tb_mc_alu.sv
// Directed scoreboard bench for mc_alu (WIDTH=32).
module tb_mc_alu;
  import mc_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALUControl = '0;
  logic [4:0]  ShiftAmount = '0;
  logic        ready, done, Zero, Overflow, CarryOut, DivByZero;
  logic [31:0] ALUOut, ALUOutHi;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mul_done_cyc;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        c;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  mc_alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .ALUControl  (ALUControl),
    .ShiftAmount (ShiftAmount),
    .ready       (ready),
    .done        (done),
    .ALUOut      (ALUOut),
    .ALUOutHi    (ALUOutHi),
    .Zero        (Zero),
    .Overflow    (Overflow),
    .CarryOut    (CarryOut),
    .DivByZero   (DivByZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    e = sbq.pop_front();
    $display("[TB] done cyc=%0d %s out=%h hi=%h z=%b ov=%b c=%b dz=%b",
             cyc, e.tag, ALUOut, ALUOutHi, Zero, Overflow, CarryOut, DivByZero);
    check({e.tag, ".cyc"}, 64'(cyc), 64'(e.cyc));
    check({e.tag, ".out"}, {32'h0, ALUOut}, {32'h0, e.out});
    check({e.tag, ".hi"},  {32'h0, ALUOutHi}, {32'h0, e.hi});
    check({e.tag, ".flags"}, {60'h0, Zero, Overflow, CarryOut, DivByZero},
          {60'h0, e.z, e.ov, e.c, e.dz});
  endtask

  // Advance to the next falling edge and score any completion seen there
  task automatic tick();
    @(negedge clk);
    if (done) begin
      if (sbq.size() == 0) check("spurious_done", {63'h0, done}, 64'h0);
      else check_pop();
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input int lat,
                       input logic [31:0] eo, input logic [31:0] eh,
                       input logic ez, input logic eov, input logic ec, input logic edz);
    exp_t e;
    ALUControl  = op;
    A           = a;
    B           = b;
    ShiftAmount = sh;
    start       = 1'b1;
    e.tag = tag; e.out = eo; e.hi = eh; e.z = ez; e.ov = eov; e.c = ec; e.dz = edz;
    e.cyc = cyc + lat;
    sbq.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("pending_after_timeout", 64'(sbq.size()), 64'h0);
    sbq.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset.out", {32'h0, ALUOut}, 64'h0);
    check("reset.hi", {32'h0, ALUOutHi}, 64'h0);
    check("reset.ctl", {58'h0, ready, done, Zero, Overflow, CarryOut, DivByZero}, 64'h20);
    rst_n = 1'b1;
    tick();

    // Test 1: ADD overflow, SUB to zero
    issue("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 1, 32'h80000000, 0, 0, 1, 0, 0);
    issue("sub_zero", OP_SUB, 32'd5, 32'd5, 5'd0, 1, 32'h0, 0, 1, 0, 0, 0);
    issue("add_carry", OP_ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 1, 32'h0, 0, 1, 0, 1, 0);
    issue("sub_borrow", OP_SUB, 32'd3, 32'd5, 5'd0, 1, 32'hFFFFFFFE, 0, 0, 0, 1, 0);
    issue("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 5'd0, 1, 32'h7FFFFFFF, 0, 0, 1, 0, 0);
    wait_idle(5);

    // Test 2: MULU with an ignored start in the middle
    issue("mulu", OP_MULU, 32'hFFFFFFFF, 32'h2, 5'd0, 33, 32'hFFFFFFFE, 32'h1, 0, 0, 0, 0);
    repeat (8) tick();
    check("mulu.busy_ready", {63'h0, ready}, 64'h0);
    ALUControl = OP_ADD; A = 32'h1; B = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(40);
    repeat (5) tick();

    // Test 3: DIVU regular
    issue("divu", OP_DIVU, 32'd100, 32'd7, 5'd0, 33, 32'd14, 32'd2, 0, 0, 0, 0);
    wait_idle(40);

    // Test 4: shifts, compares, logic, unused opcode
    issue("sra", OP_SRA, 32'h80000000, 32'h0, 5'd4, 1, 32'hF8000000, 0, 0, 0, 0, 0);
    issue("srl", OP_SRL, 32'h80000000, 32'h0, 5'd4, 1, 32'h08000000, 0, 0, 0, 0, 0);
    issue("sll0", OP_SLL, 32'hA5A5A5A5, 32'h0, 5'd0, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    issue("sll31", OP_SLL, 32'h00000003, 32'h0, 5'd31, 1, 32'h80000000, 0, 0, 0, 0, 0);
    issue("slt", OP_SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 1, 32'h1, 0, 0, 0, 0, 0);
    issue("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 1, 32'h0, 0, 1, 0, 0, 0);
    issue("xor", OP_XOR, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 1, 32'hF0F0F0F0, 0, 0, 0, 0, 0);
    issue("nor", OP_NOR, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 1, 32'h000F000F, 0, 0, 0, 0, 0);
    issue("or", OP_OR, 32'h12340000, 32'h00005678, 5'd0, 1, 32'h12345678, 0, 0, 0, 0, 0);
    issue("undef", 4'b0111, 32'h12345678, 32'h1, 5'd0, 1, 32'h0, 0, 1, 0, 0, 0);
    wait_idle(5);

    // Test 3b: DIVU by zero, leaves non-zero state for the reset test
    issue("divu_by0", OP_DIVU, 32'h1234, 32'h0, 5'd0, 1, 32'hFFFFFFFF, 32'h1234, 0, 0, 0, 1);
    wait_idle(5);

    // Test 5: reset mid-DIVU
    issue("divu_abort", OP_DIVU, 32'd1000, 32'd3, 5'd0, 33, 32'd333, 32'd1, 0, 0, 0, 0);
    repeat (13) tick();
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("abort.out", {32'h0, ALUOut}, 64'h0);
    check("abort.hi", {32'h0, ALUOutHi}, 64'h0);
    check("abort.ctl", {58'h0, ready, done, Zero, Overflow, CarryOut, DivByZero}, 64'h20);
    repeat (2) tick();
    rst_n = 1'b1;
    issue("add_after_rst", OP_ADD, 32'd2, 32'd3, 5'd0, 1, 32'd5, 0, 0, 0, 0, 0);
    wait_idle(5);
    repeat (40) tick();

    // Test 6: back-to-back AND accepted on the MULU done cycle
    issue("mulu_b2b", OP_MULU, 32'h12345678, 32'h100, 5'd0, 33, 32'h34567800, 32'h12, 0, 0, 0, 0);
    mul_done_cyc = cyc + 32;
    while (cyc < mul_done_cyc) tick();
    check("b2b.done_seen", 64'(sbq.size()), 64'h0);
    check("b2b.ready", {62'h0, done, ready}, 64'h3);
    issue("and_b2b", OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 1, 32'h00F000F0, 0, 0, 0, 0, 0);
    wait_idle(5);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
